bfs_csr_builder: RTL and testbench
==================================

Name: bfs_csr_builder

Overview:
Upstream loader for the BFS engine. It accepts an unsorted (src,dst) edge-list stream and builds the CSR graph (per-node edge_begin/edge_end plus a dst array grouped by src) using a counting sort. It then drives the BFS engine's node/edge write ports directly and pulses done, after which the controller may start the BFS.

Parameters:
SCALE, 4, log2 of node count
EDGE_FACTOR, 4, edges per node
N_NODES, 1<<SCALE (16), node count; node index = low SCALE bits of any node field
N_EDGES, N_NODES*EDGE_FACTOR (64), edge buffer depth

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a build; sampled only in S_IDLE
n_edges  in  64  number of edges to accept; latched on start
in_valid  in  1  edge stream valid
in_ready  out  1  edge stream ready
in_src  in  64  edge source node (low SCALE bits used)
in_dst  in  64  edge destination node (low SCALE bits used)
node_we_begin  out  1  write nodes_edge_begin
node_we_end  out  1  write nodes_edge_end
node_waddr  out  64  node index, zero-extended
node_edge_begin_wdata  out  64  CSR begin offset, zero-extended
node_edge_end_wdata  out  64  CSR end offset (exclusive), zero-extended
edge_we  out  1  write edges_dst
edge_waddr  out  64  CSR edge slot, zero-extended
edge_dst_wdata  out  64  dst node, zero-extended
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at completion
overflow  out  1  sticky until next start; n_edges > N_EDGES

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All outputs reset to 0. State returns to S_IDLE. Reset mid-build abandons the build. Internal arrays are not reset; S_CLR re-initialises them.
- Internal state:
  - ebuf_src/ebuf_dst[N_EDGES]
  - deg[N_NODES] (7-bit)
  - cursor[N_NODES], beg[N_NODES], endp[N_NODES]
  - cnt_target: min(n_edges, N_EDGES), 7-bit
  - acc_cnt, acc (prefix accumulator), i (loop index)
- S_IDLE:
  - start=1: latch cnt_target, set overflow = (n_edges > N_EDGES), busy<=1, i<=0, go to S_CLR.
  - start while busy is ignored.
- S_CLR: N_NODES cycles, deg[i]<=0. Then acc_cnt<=0 and go to S_ACCEPT (or S_PREFIX if cnt_target==0).
- S_ACCEPT:
  - in_ready=1 only in this state while acc_cnt < cnt_target.
  - Handshake fires when in_valid and in_ready are both 1 on a clock edge. Then store ebuf[acc_cnt]<=(src,dst), deg[src]++, acc_cnt++. At most one edge per cycle.
  - in_valid may stall arbitrarily.
  - Leave for S_PREFIX on the cycle acc_cnt reaches cnt_target; in_ready drops the next cycle.
- S_PREFIX: N_NODES cycles, node i in order:
  - beg[i]=acc; endp[i]=acc+deg[i]; cursor[i]=acc; acc+=deg[i].
  - Final acc equals acc_cnt.
- S_SCATTER: acc_cnt cycles, k=0..acc_cnt-1:
  - slot=cursor[src_k]; csr_dst[slot]<=dst_k; cursor[src_k]++.
  - Stable: edges with the same src keep arrival order.
- S_EMIT_NODES: N_NODES cycles.
  - node_we_begin=node_we_end=1, node_waddr=i, data=beg[i]/endp[i].
  - The outputs are registered, so the first write appears the cycle after entry.
- S_EMIT_EDGES: acc_cnt cycles, edge_we=1, edge_waddr=k, edge_dst_wdata=csr_dst[k]. Skipped when acc_cnt==0.
- S_DONE: one cycle; done<=1, busy<=0, go to S_IDLE. Write enables are 0 here.
- Latency: 1 + N_NODES + accept cycles + N_NODES + acc_cnt + N_NODES + acc_cnt + 1.
- Boundaries:
  - n_edges=0: all nodes emitted with begin=end=0; no edge writes.
  - n_edges>N_EDGES: exactly N_EDGES accepted, overflow=1.
  - Node with degree 0: begin==end.
  - A node whose node field exceeds the range is masked to the low SCALE bits.

Optional Feature:
BFS_CSR_DROP_SELF_LOOP_EN
- Defined: an accepted edge with src==dst (after masking) is handshaken but neither stored nor counted. It still counts toward cnt_target, so stream length is unchanged. A 7-bit counter self_loops_dropped is exported as an extra output port (self_loops_dropped out 7).
- Undefined: self-loops are stored like any edge, and the port is absent.

Decomposition:
- Shared package bfs_pkg:
  - SCALE, EDGE_FACTOR, N_NODES, N_EDGES, node_idx_t (SCALE bits), edge_idx_t (log2 N_EDGES + 1 bits)
  - csr_state_t enum {S_IDLE, S_CLR, S_ACCEPT, S_PREFIX, S_SCATTER, S_EMIT_NODES, S_EMIT_EDGES, S_DONE}
  - The same package is shared with the BFS engine.
- One natural sub-module: bfs_csr_prefix, the degree-array prefix-sum sequencer producing beg/endp/cursor. Everything else stays in the top.

Test Plan:
- Edges (0,1),(0,2),(1,3),(2,3), n_edges=4:
  - Node writes: 0:[0,2), 1:[2,3), 2:[3,4), 3..15:[4,4).
  - Edge writes in order: 1,2,3,3. done pulses once.
- Reverse-ordered sources (3,0),(1,2),(3,1),(0,5):
  - Node writes: 0:[0,1), 1:[1,2), 3:[2,4).
  - edges_dst: 5,2,0,1 (stability check for src 3).
- Same 4-edge stream with in_valid toggling 1/0 each cycle: identical writes. in_ready never high outside S_ACCEPT.
- n_edges=0: 16 node writes of [0,0), zero edge_we, done pulses, overflow=0.
- n_edges=70, 64 edges supplied: 64 handshakes, overflow=1, last node end offset=64. Then assert rst_n mid-S_SCATTER: busy=0, all write enables 0; a restart works.
- With BFS_CSR_DROP_SELF_LOOP_EN, stream (2,2),(2,3): node 2 gives [0,1), edge dst=3, self_loops_dropped=1.

Source files
------------

// File: rtl/bfs_pkg.sv
// Shared BFS definitions: graph sizing, index types and the CSR builder state encoding.
package bfs_pkg;

    localparam int SCALE       = 4;
    localparam int EDGE_FACTOR = 4;
    localparam int N_NODES     = 1 << SCALE;
    localparam int N_EDGES     = N_NODES * EDGE_FACTOR;
    localparam int SLOT_W      = $clog2(N_EDGES);
    localparam int EDGE_IDX_W  = SLOT_W + 1;

    typedef logic [SCALE-1:0]      node_idx_t;
    typedef logic [SLOT_W-1:0]     slot_t;
    typedef logic [EDGE_IDX_W-1:0] edge_idx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ACCEPT,
        S_PREFIX,
        S_SCATTER,
        S_EMIT_NODES,
        S_EMIT_EDGES,
        S_DONE
    } csr_state_t;

    localparam edge_idx_t LAST_NODE = edge_idx_t'(N_NODES - 1);

    // Requested edge count clamped to what the edge buffer can hold.
    function automatic edge_idx_t clamp_edges(input logic [63:0] n);
        return (n > 64'(N_EDGES)) ? edge_idx_t'(N_EDGES) : edge_idx_t'(n);
    endfunction

endpackage

// File: rtl/bfs_csr_prefix.sv
// Exclusive prefix-sum sequencer over the degree array: one node per enabled cycle.
module bfs_csr_prefix
    import bfs_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      en,
    input  edge_idx_t deg_i,
    output edge_idx_t beg_o,
    output edge_idx_t end_o
);

    edge_idx_t acc_q;
    edge_idx_t acc_d;

    always_comb begin
        beg_o = acc_q;
        end_o = acc_q + deg_i;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = end_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/bfs_csr_builder.sv
// Counting-sort CSR builder feeding the BFS engine write ports.
// Optional build macro BFS_CSR_DROP_SELF_LOOP_EN discards src==dst edges and counts them.
module bfs_csr_builder
    import bfs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] n_edges,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_src,
    input  logic [63:0] in_dst,
    output logic        node_we_begin,
    output logic        node_we_end,
    output logic [63:0] node_waddr,
    output logic [63:0] node_edge_begin_wdata,
    output logic [63:0] node_edge_end_wdata,
    output logic        edge_we,
    output logic [63:0] edge_waddr,
    output logic [63:0] edge_dst_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
    ,
    output logic [6:0]  self_loops_dropped
`endif
);

    node_idx_t ebuf_src [N_EDGES];
    node_idx_t ebuf_dst [N_EDGES];
    node_idx_t csr_dst  [N_EDGES];
    edge_idx_t deg      [N_NODES];
    edge_idx_t cursor   [N_NODES];
    edge_idx_t beg      [N_NODES];
    edge_idx_t endp     [N_NODES];

    csr_state_t state_q, state_d;
    edge_idx_t  i_q, i_d;
    edge_idx_t  cnt_target_q, cnt_target_d;
    edge_idx_t  rx_cnt_q, rx_cnt_d;
    edge_idx_t  acc_cnt_q, acc_cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       overflow_q, overflow_d;
    logic       node_we_q, node_we_d;
    node_idx_t  node_waddr_q, node_waddr_d;
    edge_idx_t  node_beg_q, node_beg_d;
    edge_idx_t  node_end_q, node_end_d;
    logic       edge_we_q, edge_we_d;
    edge_idx_t  edge_waddr_q, edge_waddr_d;
    node_idx_t  edge_dst_q, edge_dst_d;

    node_idx_t src_m, dst_m, i_node, sc_src;
    slot_t     i_slot, acc_slot;
    edge_idx_t deg_src, sc_slot, pre_beg, pre_end;
    logic      is_loop, pre_clr, pre_en;
    logic      deg_we, ebuf_we, cur_we, bnd_we, csr_we;
    node_idx_t deg_waddr, cur_waddr;
    edge_idx_t deg_wdata, cur_wdata;
    logic      unused_hi;

    assign src_m     = in_src[SCALE-1:0];
    assign dst_m     = in_dst[SCALE-1:0];
    assign unused_hi = ^{in_src[63:SCALE], in_dst[63:SCALE]};
    assign i_node    = i_q[SCALE-1:0];
    assign i_slot    = i_q[SLOT_W-1:0];
    assign acc_slot  = acc_cnt_q[SLOT_W-1:0];
    assign deg_src   = deg[src_m];
    assign sc_src    = ebuf_src[i_slot];
    assign sc_slot   = cursor[sc_src];

`ifdef BFS_CSR_DROP_SELF_LOOP_EN
    logic [6:0] drop_cnt_q, drop_cnt_d;
    assign is_loop            = (src_m == dst_m);
    assign self_loops_dropped = drop_cnt_q;
`else
    assign is_loop = 1'b0;
`endif

    bfs_csr_prefix u_prefix (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (pre_en),
        .deg_i (deg[i_node]),
        .beg_o (pre_beg),
        .end_o (pre_end)
    );

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        cnt_target_d = cnt_target_q;
        rx_cnt_d     = rx_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        node_we_d    = 1'b0;
        node_waddr_d = node_waddr_q;
        node_beg_d   = node_beg_q;
        node_end_d   = node_end_q;
        edge_we_d    = 1'b0;
        edge_waddr_d = edge_waddr_q;
        edge_dst_d   = edge_dst_q;
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
        drop_cnt_d   = drop_cnt_q;
`endif
        in_ready  = 1'b0;
        pre_clr   = 1'b0;
        pre_en    = 1'b0;
        deg_we    = 1'b0;
        deg_waddr = i_node;
        deg_wdata = '0;
        ebuf_we   = 1'b0;
        cur_we    = 1'b0;
        cur_waddr = i_node;
        cur_wdata = pre_beg;
        bnd_we    = 1'b0;
        csr_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_target_d = clamp_edges(n_edges);
                    overflow_d   = (n_edges > 64'(N_EDGES));
                    busy_d       = 1'b1;
                    i_d          = '0;
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
                    drop_cnt_d   = '0;
`endif
                    state_d      = S_CLR;
                end
            end
            S_CLR: begin
                deg_we  = 1'b1;
                pre_clr = 1'b1;
                i_d     = i_q + 1'b1;
                if (i_q == LAST_NODE) begin
                    i_d       = '0;
                    acc_cnt_d = '0;
                    rx_cnt_d  = '0;
                    state_d   = (cnt_target_q == '0) ? S_PREFIX : S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                in_ready = (rx_cnt_q < cnt_target_q);
                if (in_valid && in_ready) begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    // Dropped self-loops still consume a slot of the requested stream length.
                    if (is_loop) begin
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
                        drop_cnt_d = drop_cnt_q + 1'b1;
`endif
                    end else begin
                        ebuf_we   = 1'b1;
                        deg_we    = 1'b1;
                        deg_waddr = src_m;
                        deg_wdata = deg_src + 1'b1;
                        acc_cnt_d = acc_cnt_q + 1'b1;
                    end
                    if (rx_cnt_d == cnt_target_q) begin
                        state_d = S_PREFIX;
                    end
                end
            end
            S_PREFIX: begin
                pre_en = 1'b1;
                bnd_we = 1'b1;
                cur_we = 1'b1;
                i_d    = i_q + 1'b1;
                if (i_q == LAST_NODE) begin
                    i_d     = '0;
                    state_d = (acc_cnt_q == '0) ? S_EMIT_NODES : S_SCATTER;
                end
            end
            S_SCATTER: begin
                // Walking the buffer in arrival order keeps same-src edges stable.
                csr_we    = 1'b1;
                cur_we    = 1'b1;
                cur_waddr = sc_src;
                cur_wdata = sc_slot + 1'b1;
                i_d       = i_q + 1'b1;
                if (edge_idx_t'(i_q + 1'b1) == acc_cnt_q) begin
                    i_d     = '0;
                    state_d = S_EMIT_NODES;
                end
            end
            S_EMIT_NODES: begin
                node_we_d    = 1'b1;
                node_waddr_d = i_node;
                node_beg_d   = beg[i_node];
                node_end_d   = endp[i_node];
                i_d          = i_q + 1'b1;
                if (i_q == LAST_NODE) begin
                    i_d     = '0;
                    state_d = (acc_cnt_q == '0) ? S_DONE : S_EMIT_EDGES;
                end
            end
            S_EMIT_EDGES: begin
                edge_we_d    = 1'b1;
                edge_waddr_d = i_q;
                edge_dst_d   = csr_dst[i_slot];
                i_d          = i_q + 1'b1;
                if (edge_idx_t'(i_q + 1'b1) == acc_cnt_q) begin
                    i_d     = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Storage arrays carry no reset; S_CLR and S_PREFIX rewrite everything a build reads.
    always_ff @(posedge clk) begin
        if (deg_we) begin
            deg[deg_waddr] <= deg_wdata;
        end
        if (ebuf_we) begin
            ebuf_src[acc_slot] <= src_m;
            ebuf_dst[acc_slot] <= dst_m;
        end
        if (cur_we) begin
            cursor[cur_waddr] <= cur_wdata;
        end
        if (bnd_we) begin
            beg[i_node]  <= pre_beg;
            endp[i_node] <= pre_end;
        end
        if (csr_we) begin
            csr_dst[sc_slot[SLOT_W-1:0]] <= ebuf_dst[i_slot];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            cnt_target_q <= '0;
            rx_cnt_q     <= '0;
            acc_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            node_we_q    <= 1'b0;
            node_waddr_q <= '0;
            node_beg_q   <= '0;
            node_end_q   <= '0;
            edge_we_q    <= 1'b0;
            edge_waddr_q <= '0;
            edge_dst_q   <= '0;
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
            drop_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            cnt_target_q <= cnt_target_d;
            rx_cnt_q     <= rx_cnt_d;
            acc_cnt_q    <= acc_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            node_we_q    <= node_we_d;
            node_waddr_q <= node_waddr_d;
            node_beg_q   <= node_beg_d;
            node_end_q   <= node_end_d;
            edge_we_q    <= edge_we_d;
            edge_waddr_q <= edge_waddr_d;
            edge_dst_q   <= edge_dst_d;
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    assign node_we_begin         = node_we_q;
    assign node_we_end           = node_we_q;
    assign node_waddr            = 64'(node_waddr_q);
    assign node_edge_begin_wdata = 64'(node_beg_q);
    assign node_edge_end_wdata   = 64'(node_end_q);
    assign edge_we               = edge_we_q;
    assign edge_waddr            = 64'(edge_waddr_q);
    assign edge_dst_wdata        = 64'(edge_dst_q);
    assign busy                  = busy_q;
    assign done                  = done_q;
    assign overflow              = overflow_q;

endmodule

// File: tb/tb_bfs_csr_builder.sv
// Scoreboard bench for bfs_csr_builder: a reference counting sort queues the expected
// node/edge writes, a negedge monitor pops and compares them as the DUT emits.
module tb_bfs_csr_builder;

    localparam int NN = 16;
    localparam int NE = 64;
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct { int addr; int b; int e; } node_exp_t;
    typedef struct { int addr; int dst; } edge_exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] n_edges;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_src;
    logic [63:0] in_dst;
    logic        node_we_begin;
    logic        node_we_end;
    logic [63:0] node_waddr;
    logic [63:0] node_edge_begin_wdata;
    logic [63:0] node_edge_end_wdata;
    logic        edge_we;
    logic [63:0] edge_waddr;
    logic [63:0] edge_dst_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
    logic [6:0]  self_loops_dropped;
`endif

    bfs_csr_builder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .n_edges               (n_edges),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_src                (in_src),
        .in_dst                (in_dst),
        .node_we_begin         (node_we_begin),
        .node_we_end           (node_we_end),
        .node_waddr            (node_waddr),
        .node_edge_begin_wdata (node_edge_begin_wdata),
        .node_edge_end_wdata   (node_edge_end_wdata),
        .edge_we               (edge_we),
        .edge_waddr            (edge_waddr),
        .edge_dst_wdata        (edge_dst_wdata),
        .busy                  (busy),
        .done                  (done),
        .overflow              (overflow)
`ifdef BFS_CSR_DROP_SELF_LOOP_EN
        ,
        .self_loops_dropped    (self_loops_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    node_exp_t   node_q[$];
    edge_exp_t   edge_q[$];
    int          done_seen = 0;
    int          rdy_bad   = 0;
    logic [63:0] last_end  = '0;
    int          exp_drops = 0;
    logic [63:0] e_src [NE+8];
    logic [63:0] e_dst [NE+8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (node_we_begin) begin
                if (node_q.size() == 0) begin
                    check("node_unexpected", 64'd1, 64'd0);
                end else begin
                    node_exp_t ne;
                    ne = node_q.pop_front();
                    check("node_addr", node_waddr, 64'(ne.addr));
                    check("node_begin", node_edge_begin_wdata, 64'(ne.b));
                    check("node_end", node_edge_end_wdata, 64'(ne.e));
                    check("node_we_end", {63'd0, node_we_end}, 64'd1);
                    last_end = node_edge_end_wdata;
                end
            end
            if (edge_we) begin
                if (edge_q.size() == 0) begin
                    check("edge_unexpected", 64'd1, 64'd0);
                end else begin
                    edge_exp_t ee;
                    ee = edge_q.pop_front();
                    check("edge_addr", edge_waddr, 64'(ee.addr));
                    check("edge_dst", edge_dst_wdata, 64'(ee.dst));
                end
            end
            if (done) done_seen++;
            if (in_ready && (!busy || node_we_begin || edge_we)) rdy_bad++;
        end
    end

    task automatic set_edge(input int k, input logic [63:0] s, input logic [63:0] d);
        e_src[k] = s;
        e_dst[k] = d;
    endtask

    // Runs one build; abort_at>0 pulls rst_n at that cycle count instead of finishing.
    task automatic run_build(input logic [63:0] n, input int n_sup, input bit toggle,
                             input int abort_at, input bit exp_ovf);
        int tgt, st, run, a_cyc, lat_exp, lat, k, hs;
        int kept[$];
        bit ph, aborted;
        tgt = (n > 64'(NE)) ? NE : int'(n);
        exp_drops = 0;
        for (int j = 0; j < tgt; j++) begin
            if (DROP && (e_src[j][3:0] == e_dst[j][3:0])) exp_drops++;
            else kept.push_back(j);
        end
        st  = kept.size();
        run = 0;
        for (int v = 0; v < NN; v++) begin
            int b;
            b = run;
            foreach (kept[m]) begin
                if (int'(e_src[kept[m]][3:0]) == v) begin
                    edge_q.push_back('{addr: run, dst: int'(e_dst[kept[m]][3:0])});
                    run++;
                end
            end
            node_q.push_back('{addr: v, b: b, e: run});
        end
        a_cyc   = (tgt == 0) ? 0 : (toggle ? 2 * tgt - 1 : tgt);
        lat_exp = 1 + NN + a_cyc + NN + st + NN + st + 1;

        done_seen = 0;
        rdy_bad   = 0;
        @(negedge clk);
        start   = 1'b1;
        n_edges = n;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        lat = 1; k = 0; hs = 0; ph = 1'b1; aborted = 1'b0;
        while (!done && lat < 4000 && !aborted) begin
            if (abort_at != 0 && lat == abort_at) begin
                aborted = 1'b1;
            end else begin
                if (k < n_sup && (!toggle || ph)) begin
                    in_valid = 1'b1;
                    in_src   = e_src[k];
                    in_dst   = e_dst[k];
                end else begin
                    in_valid = 1'b0;
                end
                ph = !ph;
                if (in_valid && in_ready) begin
                    k++;
                    hs++;
                end
                @(negedge clk);
                lat++;
            end
        end
        in_valid = 1'b0;

        if (aborted) begin
            check("abort_busy_before", {63'd0, busy}, 64'd1);
            check("abort_ovf_before", {63'd0, overflow}, {63'd0, exp_ovf});
            rst_n = 1'b0;
            #1;
            check("abort_busy", {63'd0, busy}, 64'd0);
            check("abort_we", {62'd0, node_we_begin, edge_we}, 64'd0);
            check("abort_ready", {63'd0, in_ready}, 64'd0);
            check("abort_ovf", {63'd0, overflow}, 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            node_q.delete();
            edge_q.delete();
        end else begin
            check("done_seen", {63'd0, done}, 64'd1);
            check("busy_at_done", {63'd0, busy}, 64'd0);
            check("latency", 64'(lat), 64'(lat_exp));
            check("handshakes", 64'(hs), 64'(tgt));
            check("overflow", {63'd0, overflow}, {63'd0, exp_ovf});
            repeat (3) @(negedge clk);
            check("done_pulses", 64'(done_seen), 64'd1);
            check("node_left", 64'(node_q.size()), 64'd0);
            check("edge_left", 64'(edge_q.size()), 64'd0);
            check("ready_outside", 64'(rdy_bad), 64'd0);
            check("we_idle", {62'd0, node_we_begin, edge_we}, 64'd0);
            node_q.delete();
            edge_q.delete();
        end
    endtask

    task automatic load_basic();
        set_edge(0, 64'd0, 64'd1);
        set_edge(1, 64'd0, 64'd2);
        set_edge(2, 64'd1, 64'd3);
        set_edge(3, 64'd2, 64'd3);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        n_edges  = '0;
        in_valid = 1'b0;
        in_src   = '0;
        in_dst   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_we", {61'd0, node_we_begin, node_we_end, edge_we}, 64'd0);
        check("rst_data", node_waddr | node_edge_end_wdata | edge_dst_wdata, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load_basic();
        run_build(64'd4, 4, 1'b0, 0, 1'b0);

        set_edge(0, 64'd3, 64'd0);
        set_edge(1, 64'd1, 64'd2);
        set_edge(2, 64'd3, 64'd1);
        set_edge(3, 64'd0, 64'd5);
        run_build(64'd4, 4, 1'b0, 0, 1'b0);

        load_basic();
        run_build(64'd4, 4, 1'b1, 0, 1'b0);

        run_build(64'd0, 0, 1'b0, 0, 1'b0);
        check("empty_last_end", last_end, 64'd0);

        // Out-of-range high bits exercise masking; dst offset avoids self-loops.
        for (int j = 0; j < NE; j++) begin
            e_src[j] = {$urandom(), $urandom()};
            e_dst[j] = {$urandom(), $urandom()};
            e_dst[j][3:0] = e_src[j][3:0] + 4'($urandom_range(1, 15));
        end
        run_build(64'd70, NE, 1'b0, 0, 1'b1);
        check("ovf_last_end", last_end, 64'd64);

        run_build(64'd70, NE, 1'b0, 120, 1'b1);

        load_basic();
        run_build(64'd4, 4, 1'b1, 0, 1'b0);
        check("restart_last_end", last_end, 64'd4);

`ifdef BFS_CSR_DROP_SELF_LOOP_EN
        set_edge(0, 64'd2, 64'd2);
        set_edge(1, 64'd2, 64'd3);
        run_build(64'd2, 2, 1'b0, 0, 1'b0);
        check("self_loops_dropped", 64'(self_loops_dropped), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
